// File: rtl/divider_control.sv
// divider_control: sequential restoring divider, controller plus datapath.
// ClearA_LoadB loads the dividend. Run (a level input) starts one division
// with Din as the divisor, producing one quotient bit every two cycles.
// Optional build macro: SIGNED_DIV_EN selects two's complement operands.
// It adds the FIX state and the operand sign registers.
//
// state | meaning
// IDLE  | waiting; load dividend or start on Run
// SHIFT | shift {A,Q} left by one
// SUB   | trial subtract divisor, set quotient bit if it fits
// FIX   | apply operand signs to quotient/remainder (signed build only)
// HOLD  | result valid, Done high; wait for Run to drop
module divider_control #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [2:0] {IDLE, SHIFT, SUB, FIX, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, SHIFT, SUB, HOLD} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt;
  logic             div_zero;
  logic [WIDTH:0]   trial;

`ifdef SIGNED_DIV_EN
  logic sign_n;
  logic sign_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // -2^(WIDTH-1) maps onto itself, which reads correctly as unsigned
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  assign trial   = a_reg - {1'b0, b_reg};
  assign Quot    = q_reg;
  assign Rem     = a_reg[WIDTH-1:0];
  assign DivZero = div_zero;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        // load has priority over Run in the same cycle
        if (!ClearA_LoadB && Run) state_nxt = (Din != '0) ? SHIFT : HOLD;
      end
      SHIFT: begin
        Busy      = 1'b1;
        state_nxt = SUB;
      end
      SUB: begin
        Busy = 1'b1;
        if (cnt == CNT_LAST) begin
`ifdef SIGNED_DIV_EN
          state_nxt = FIX;
`else
          state_nxt = HOLD;
`endif
        end else begin
          state_nxt = SHIFT;
        end
      end
`ifdef SIGNED_DIV_EN
      FIX: begin
        Busy      = 1'b1;
        state_nxt = HOLD;
      end
`endif
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: A/Q/B registers, iteration counter and divide-by-zero flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_reg    <= '0;
      q_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_n   <= 1'b0;
      sign_d   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            a_reg    <= '0;
            div_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            q_reg    <= mag(Din);
            sign_n   <= Din[WIDTH-1];
`else
            q_reg    <= Din;
`endif
          end else if (Run) begin
            if (Din != '0) begin
              cnt    <= '0;
`ifdef SIGNED_DIV_EN
              b_reg  <= mag(Din);
              sign_d <= Din[WIDTH-1];
`else
              b_reg  <= Din;
`endif
            end else begin
              // no iteration: quotient saturates, remainder shows the dividend
              div_zero <= 1'b1;
              q_reg    <= '1;
`ifdef SIGNED_DIV_EN
              a_reg    <= sign_n ? (~{1'b0, q_reg} + (WIDTH+1)'(1)) : {1'b0, q_reg};
`else
              a_reg    <= {1'b0, q_reg};
`endif
            end
          end
        end
        SHIFT: begin
          a_reg <= {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
          q_reg <= {q_reg[WIDTH-2:0], 1'b0};
        end
        SUB: begin
          // restore by simply not writing A when the trial went negative
          if (!trial[WIDTH]) begin
            a_reg    <= trial;
            q_reg[0] <= 1'b1;
          end
          if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          if (sign_n ^ sign_d) q_reg <= ~q_reg + WIDTH'(1);
          if (sign_n)          a_reg <= ~a_reg + (WIDTH+1)'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
